// File: rtl/oclib_axi4_ram_target.sv
// AXI4 slave backed by an on-chip word RAM: independent write/read engines, INCR/FIXED bursts, byte strobes.
// Optional per-beat decode-error range check: define OCLIB_AXI4_RAM_TARGET_DECERR_EN.
package oclib_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
  } axi4_a_s;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } axi4_w64_s;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } axi4_b_s;
  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } axi4_r64_s;
  typedef struct packed {
    axi4_a_s   aw;
    logic      awvalid;
    axi4_w64_s w;
    logic      wvalid;
    logic      bready;
    axi4_a_s   ar;
    logic      arvalid;
    logic      rready;
  } axi4m_64_s;
  typedef struct packed {
    logic      awready;
    logic      wready;
    axi4_b_s   b;
    logic      bvalid;
    logic      arready;
    axi4_r64_s r;
    logic      rvalid;
  } axi4m_64_fb_s;
endpackage

module oclib_axi4_ram_target #(
  parameter type AxiType   = oclib_pkg::axi4m_64_s,
  parameter type AxiFbType = oclib_pkg::axi4m_64_fb_s,
  parameter int  Depth     = 1024
) (
  input  logic     clock,
  input  logic     reset,
  input  AxiType   axi,
  output AxiFbType axiFb
);
  localparam int DW  = $bits(axi.w.data);
  localparam int AW  = $bits(axi.aw.addr);
  localparam int IDW = $bits(axi.aw.id);
  localparam int BPW = DW / 8;
  localparam int OFF = $clog2(BPW);
  localparam int IW  = $clog2(Depth);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  w_state_e         w_state_q, w_state_d;
  logic [IDW-1:0]   aw_id_q, aw_id_d;
  logic [AW-1:0]    w_addr_q, w_addr_d;
  logic [7:0]       w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic             w_fixed_q, w_fixed_d, w_slverr_q, w_slverr_d, w_decerr_q, w_decerr_d;
  logic             awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;

  r_state_e         r_state_q, r_state_d;
  logic [IDW-1:0]   r_id_q, r_id_d;
  logic [AW-1:0]    r_addr_q, r_addr_d;
  logic [7:0]       r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic             r_fixed_q, r_fixed_d, arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]       rresp_q, rresp_d;

  logic [DW-1:0]    mem [Depth];
  logic [DW-1:0]    rdata_q;
  logic [IW-1:0]    w_idx, r_idx;
  logic             w_hs, w_last_beat, w_oob, r_oob, r_load, mem_we;
  logic             unused_bits;

  assign w_idx       = w_addr_q[OFF +: IW];
  assign r_idx       = r_addr_q[OFF +: IW];
  assign w_hs        = axi.wvalid && wready_q;
  assign w_last_beat = (w_beat_q == w_len_q);
  assign mem_we      = w_hs && !w_oob;
  assign unused_bits = ^{axi.aw.size, axi.aw.lock, axi.aw.cache, axi.aw.prot,
                         axi.ar.size, axi.ar.lock, axi.ar.cache, axi.ar.prot};

`ifdef OCLIB_AXI4_RAM_TARGET_DECERR_EN
  assign w_oob = (w_addr_q >> (OFF + IW)) != '0;
  assign r_oob = (r_addr_q >> (OFF + IW)) != '0;
`else
  assign w_oob = 1'b0;
  assign r_oob = 1'b0;
`endif

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    w_state_d  = w_state_q;   aw_id_d    = aw_id_q;    w_addr_d  = w_addr_q;
    w_len_d    = w_len_q;     w_beat_d   = w_beat_q;   w_fixed_d = w_fixed_q;
    w_slverr_d = w_slverr_q;  w_decerr_d = w_decerr_q; bresp_d   = bresp_q;
    awready_d  = awready_q;   wready_d   = wready_q;   bvalid_d  = bvalid_q;
    unique case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (axi.awvalid && awready_q) begin
          aw_id_d    = axi.aw.id;
          w_addr_d   = axi.aw.addr;
          w_len_d    = axi.aw.len;
          w_fixed_d  = (axi.aw.burst == 2'd0);
          w_beat_d   = '0;
          w_slverr_d = 1'b0;
          w_decerr_d = 1'b0;
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          w_state_d  = W_DATA;
        end
      end
      W_DATA: if (w_hs) begin
        // wlast is only a consistency check; the burst length always comes from AW.
        w_slverr_d = w_slverr_q | (axi.w.last != w_last_beat);
        w_decerr_d = w_decerr_q | w_oob;
        if (!w_fixed_q) w_addr_d = w_addr_q + AW'(BPW);
        if (w_last_beat) begin
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = w_decerr_d ? 2'd3 : (w_slverr_d ? 2'd2 : 2'd0);
          w_state_d = W_RESP;
        end else begin
          w_beat_d = w_beat_q + 8'd1;
        end
      end
      W_RESP: if (axi.bready) begin
        bvalid_d  = 1'b0;
        awready_d = 1'b1;
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;  r_id_d    = r_id_q;    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;    r_beat_d  = r_beat_q;  r_fixed_d = r_fixed_q;
    arready_d = arready_q;  rvalid_d  = rvalid_q;  rlast_d   = rlast_q;
    rresp_d   = rresp_q;    r_load    = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (axi.arvalid && arready_q) begin
          r_id_d    = axi.ar.id;
          r_addr_d  = axi.ar.addr;
          r_len_d   = axi.ar.len;
          r_fixed_d = (axi.ar.burst == 2'd0);
          r_beat_d  = '0;
          arready_d = 1'b0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (!rvalid_q) begin
          r_load   = 1'b1;
          rvalid_d = 1'b1;
          rlast_d  = (r_beat_q == r_len_q);
        end else if (axi.rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            r_load   = 1'b1;
            r_beat_d = r_beat_q + 8'd1;
            rlast_d  = ((r_beat_q + 8'd1) == r_len_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (r_load) begin
      rresp_d = r_oob ? 2'd3 : 2'd0;
      if (!r_fixed_q) r_addr_d = r_addr_q + AW'(BPW);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state_q <= W_IDLE; aw_id_q <= '0; w_addr_q <= '0; w_len_q <= '0; w_beat_q <= '0;
      w_fixed_q <= 1'b0; w_slverr_q <= 1'b0; w_decerr_q <= 1'b0; bresp_q <= '0;
      awready_q <= 1'b0; wready_q <= 1'b0; bvalid_q <= 1'b0;
      r_state_q <= R_IDLE; r_id_q <= '0; r_addr_q <= '0; r_len_q <= '0; r_beat_q <= '0;
      r_fixed_q <= 1'b0; arready_q <= 1'b0; rvalid_q <= 1'b0; rlast_q <= 1'b0; rresp_q <= '0;
    end else begin
      w_state_q <= w_state_d; aw_id_q <= aw_id_d; w_addr_q <= w_addr_d; w_len_q <= w_len_d;
      w_beat_q <= w_beat_d; w_fixed_q <= w_fixed_d; w_slverr_q <= w_slverr_d;
      w_decerr_q <= w_decerr_d; bresp_q <= bresp_d;
      awready_q <= awready_d; wready_q <= wready_d; bvalid_q <= bvalid_d;
      r_state_q <= r_state_d; r_id_q <= r_id_d; r_addr_q <= r_addr_d; r_len_q <= r_len_d;
      r_beat_q <= r_beat_d; r_fixed_q <= r_fixed_d; arready_q <= arready_d;
      rvalid_q <= rvalid_d; rlast_q <= rlast_d; rresp_q <= rresp_d;
    end
  end

  // NOTE: the RAM array and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < BPW; i++) begin
        if (axi.w.strb[i]) mem[w_idx][i*8 +: 8] <= axi.w.data[i*8 +: 8];
      end
    end
    if (r_load) rdata_q <= mem[r_idx];
  end

  always_comb begin
    axiFb         = '0;
    axiFb.awready = awready_q;
    axiFb.wready  = wready_q;
    axiFb.bvalid  = bvalid_q;
    axiFb.b.id    = aw_id_q;
    axiFb.b.resp  = bresp_q;
    axiFb.arready = arready_q;
    axiFb.rvalid  = rvalid_q;
    axiFb.r.id    = r_id_q;
    axiFb.r.resp  = rresp_q;
    axiFb.r.last  = rlast_q;
    axiFb.r.data  = (rvalid_q && rresp_q == 2'd0) ? rdata_q : '0;
  end
endmodule

// File: tb/tb_oclib_axi4_ram_target.sv
// Self-checking bench for oclib_axi4_ram_target: single-beat vector table, bursts, wlast errors,
// reset abort and the decode-range case (expectations follow OCLIB_AXI4_RAM_TARGET_DECERR_EN).
module tb_oclib_axi4_ram_target;
  import oclib_pkg::*;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  axi4m_64_s    axi;
  axi4m_64_fb_s axi_fb;

  int errors = 0;
  int checks = 0;
  string tag = "init";

  typedef struct {logic [3:0] id; logic [1:0] resp;} b_exp_t;
  typedef struct {logic [63:0] data; logic [63:0] mask; logic [3:0] id; logic [1:0] resp; logic last;} r_exp_t;
  typedef struct {
    logic [31:0] waddr; logic [63:0] wdata; logic [7:0] strb; logic [3:0] wid; logic [1:0] bresp;
    logic [31:0] raddr; logic [3:0] rid; logic [63:0] rdata; logic [63:0] rmask; logic [1:0] rresp;
  } vec_t;

  b_exp_t b_q[$];
  r_exp_t r_q[$];
  vec_t   vecs[7];

  oclib_axi4_ram_target #(.Depth(1024)) dut (
    .clock (clock),
    .reset (reset),
    .axi   (axi),
    .axiFb (axi_fb)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL [%s] %s: got 0x%0h, expected 0x%0h", tag, name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // n_send >= 0 sends only that many beats and abandons the burst (no B handling).
  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input logic [63:0] base, input logic [7:0] strb,
                          input bit bad_last, input int n_send);
    int n;
    int t;
    b_exp_t e;
    n = (n_send < 0) ? int'(len) + 1 : n_send;
    axi.aw = '0; axi.aw.addr = addr; axi.aw.id = id; axi.aw.len = len; axi.aw.burst = burst;
    axi.awvalid = 1'b1;
    t = 0;
    while (!axi_fb.awready && t < 200) begin step(); t++; end
    if (t >= 200) check("aw_timeout", 0, 1);
    step();
    axi.awvalid = 1'b0;
    for (int beat = 0; beat < n; beat++) begin
      axi.w.data = base + 64'(beat);
      axi.w.strb = strb;
      axi.w.last = bad_last ? (beat == 0) : (beat == int'(len));
      axi.wvalid = 1'b1;
      t = 0;
      while (!axi_fb.wready && t < 200) begin step(); t++; end
      if (t >= 200) check("w_timeout", 0, 1);
      step();
    end
    axi.wvalid = 1'b0;
    axi.w.last = 1'b0;
    if (n_send >= 0) return;
    check("b_one_cycle_after_last_w", axi_fb.bvalid, 1);
    axi.bready = 1'b1;
    t = 0;
    while (!axi_fb.bvalid && t < 200) begin step(); t++; end
    if (t >= 200) check("b_timeout", 0, 1);
    else if (b_q.size() == 0) check("b_unexpected", 1, 0);
    else begin
      e = b_q.pop_front();
      check("bid", axi_fb.b.id, e.id);
      check("bresp", axi_fb.b.resp, e.resp);
    end
    step();
    axi.bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input bit toggle);
    int t;
    int got;
    bit stalled;
    axi4_r64_s saved;
    r_exp_t e;
    axi.ar = '0; axi.ar.addr = addr; axi.ar.id = id; axi.ar.len = len; axi.ar.burst = burst;
    axi.arvalid = 1'b1;
    t = 0;
    while (!axi_fb.arready && t < 200) begin step(); t++; end
    if (t >= 200) check("ar_timeout", 0, 1);
    step();
    axi.arvalid = 1'b0;
    check("rvalid_low_cycle_after_ar", axi_fb.rvalid, 0);
    step();
    check("rvalid_two_cycles_after_ar", axi_fb.rvalid, 1);
    got = 0;
    stalled = 1'b0;
    saved = '0;
    t = 0;
    while (got <= int'(len) && t < 2000) begin
      axi.rready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (axi_fb.rvalid) begin
        if (stalled) check("r_stable_while_stalled", (axi_fb.r == saved), 1);
        if (axi.rready) begin
          stalled = 1'b0;
          if (r_q.size() == 0) check("r_unexpected", 1, 0);
          else begin
            e = r_q.pop_front();
            check("rdata", axi_fb.r.data & e.mask, e.data & e.mask);
            check("rid", axi_fb.r.id, e.id);
            check("rresp", axi_fb.r.resp, e.resp);
            check("rlast", axi_fb.r.last, e.last);
          end
          got++;
        end else begin
          saved = axi_fb.r;
          stalled = 1'b1;
        end
      end
      step();
      t++;
    end
    axi.rready = 1'b0;
    if (got <= int'(len)) check("r_timeout", 0, 1);
  endtask

  initial begin
    int bv_count;
    vecs[0] = '{32'h10,   64'h0000_0000_DEAD_BEEF, 8'h0F, 4'd5,  2'd0, 32'h10,   4'd3,  64'h0000_0000_DEAD_BEEF, 64'h0000_0000_FFFF_FFFF, 2'd0};
    vecs[1] = '{32'h0,    64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 4'd1,  2'd0, 32'h0,    4'd1,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0};
    vecs[2] = '{32'h0,    64'h0000_0000_1122_3344, 8'h05, 4'd4,  2'd0, 32'h0,    4'd6,  64'hFFFF_FFFF_FF22_FF44, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0};
    vecs[3] = '{32'h4,    64'hCAFE_F00D_0000_0000, 8'hF0, 4'd10, 2'd0, 32'h0,    4'd11, 64'hCAFE_F00D_FF22_FF44, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0};
    vecs[4] = '{32'h1FF8, 64'h0123_4567_89AB_CDEF, 8'hFF, 4'd2,  2'd0, 32'h1FF8, 4'd9,  64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0};
`ifdef OCLIB_AXI4_RAM_TARGET_DECERR_EN
    vecs[5] = '{32'h2000, 64'h5555_5555_5555_5555, 8'hFF, 4'd7,  2'd3, 32'h0,    4'd8,  64'hCAFE_F00D_FF22_FF44, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0};
`else
    vecs[5] = '{32'h2000, 64'h5555_5555_5555_5555, 8'hFF, 4'd7,  2'd0, 32'h0,    4'd8,  64'h5555_5555_5555_5555, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0};
`endif
    vecs[6] = '{32'h3F0,  64'h0F0E_0D0C_0B0A_0908, 8'hFF, 4'd15, 2'd0, 32'h3F0,  4'd14, 64'h0F0E_0D0C_0B0A_0908, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0};

    axi = '0;
    reset = 1'b0;
    repeat (3) step();
    tag = "reset";
    check("fb_zero_in_reset", (axi_fb == '0), 1);
    reset = 1'b1;
    #1;
    check("awready_low_at_release", axi_fb.awready, 0);
    step();
    check("awready_after_release", axi_fb.awready, 1);
    check("arready_after_release", axi_fb.arready, 1);

    for (int i = 0; i < 7; i++) begin
      tag = $sformatf("vec%0d", i);
      b_q.push_back('{vecs[i].wid, vecs[i].bresp});
      do_write(vecs[i].waddr, vecs[i].wid, 8'd0, 2'd1, vecs[i].wdata, vecs[i].strb, 1'b0, -1);
      r_q.push_back('{vecs[i].rdata, vecs[i].rmask, vecs[i].rid, vecs[i].rresp, 1'b1});
      do_read(vecs[i].raddr, vecs[i].rid, 8'd0, 2'd1, 1'b0);
    end

    tag = "decode_range_read";
`ifdef OCLIB_AXI4_RAM_TARGET_DECERR_EN
    r_q.push_back('{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd5, 2'd3, 1'b1});
`else
    r_q.push_back('{64'h5555_5555_5555_5555, 64'hFFFF_FFFF_FFFF_FFFF, 4'd5, 2'd0, 1'b1});
`endif
    do_read(32'h2000, 4'd5, 8'd0, 2'd1, 1'b0);

    tag = "incr_burst";
    b_q.push_back('{4'd2, 2'd0});
    do_write(32'h100, 4'd2, 8'd3, 2'd1, 64'hA0, 8'hFF, 1'b0, -1);
    for (int k = 0; k < 4; k++) r_q.push_back('{64'hA0 + 64'(k), 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 2'd0, (k == 3)});
    do_read(32'h100, 4'd1, 8'd3, 2'd1, 1'b1);

    tag = "fixed_burst";
    b_q.push_back('{4'd3, 2'd0});
    do_write(32'h28, 4'd3, 8'd0, 2'd1, 64'h77, 8'hFF, 1'b0, -1);
    b_q.push_back('{4'd3, 2'd0});
    do_write(32'h20, 4'd3, 8'd1, 2'd0, 64'h1, 8'hFF, 1'b0, -1);
    r_q.push_back('{64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 4'd4, 2'd0, 1'b1});
    do_read(32'h20, 4'd4, 8'd0, 2'd1, 1'b0);
    r_q.push_back('{64'h77, 64'hFFFF_FFFF_FFFF_FFFF, 4'd4, 2'd0, 1'b1});
    do_read(32'h28, 4'd4, 8'd0, 2'd1, 1'b0);

    tag = "wlast_mismatch";
    b_q.push_back('{4'd4, 2'd2});
    do_write(32'h300, 4'd4, 8'd1, 2'd1, 64'hC0, 8'hFF, 1'b1, -1);
    r_q.push_back('{64'hC0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd2, 2'd0, 1'b0});
    r_q.push_back('{64'hC1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd2, 2'd0, 1'b1});
    do_read(32'h300, 4'd2, 8'd1, 2'd1, 1'b0);

    tag = "reset_abort";
    do_write(32'h200, 4'd6, 8'd3, 2'd1, 64'hB0, 8'hFF, 1'b0, 2);
    reset = 1'b0;
    #1;
    check("fb_zero_mid_burst_reset", (axi_fb == '0), 1);
    step();
    check("fb_zero_reset_held", (axi_fb == '0), 1);
    reset = 1'b1;
    axi.bready = 1'b1;
    bv_count = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (axi_fb.bvalid) bv_count++;
    end
    axi.bready = 1'b0;
    check("no_b_after_abort", bv_count, 0);
    r_q.push_back('{64'hB0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd7, 2'd0, 1'b0});
    r_q.push_back('{64'hB1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd7, 2'd0, 1'b1});
    do_read(32'h200, 4'd7, 8'd1, 2'd1, 1'b0);

    tag = "end";
    check("scoreboard_drained", b_q.size() + r_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
